// File: rtl/mcu32x_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : mcu32x_mem_resp
// Description : Wait-state memory responder for the MCU32X core. Accepts one
//               read or write at a time while idle, inserts WAIT_CYCLES wait
//               states, then completes with a one-cycle ack. Read data is
//               registered and held until the next successful read. Memory
//               contents are not reset.
//
//               Optional feature macro: MCU32X_MEM_ERR_EN
//                 defined   - misaligned or out-of-range accesses complete
//                             with ack=1/err=1, no memory write, rdata held
//                 undefined - err tied low, low address bits and bits above
//                             the word index ignored (accesses wrap)
//
// Ports       : clk        - clock, all state updates on rising edge
//               reset      - synchronous active-high reset
//               mem_read   - read request from the core
//               mem_write  - write request from the core
//               address    - byte address of the request
//               wdata      - write data from the core result bus
//               ready      - responder can accept a request this cycle
//               ack        - one-cycle completion pulse
//               rdata      - registered read data
//               err        - error qualifier, valid only with ack
// Revision    : 1.0 - initial release
// ============================================================================
module mcu32x_mem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Counter value on the last wait cycle; unused when WAIT_CYCLES is zero.
    localparam logic [3:0] c_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_wait_cnt;
    logic               r_op_write;
    logic [c_IDX_W-1:0] r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_eff_write;
    logic [c_IDX_W-1:0] w_eff_idx;
    logic [31:0]        w_eff_wdata;
    logic               w_eff_bad;

    assign w_accept = (r_state == c_IDLE) && (mem_read ^ mem_write);

    // With WAIT_CYCLES=0 the access commits on its accept edge, so the
    // request fields come straight from the ports while idle.
    assign w_eff_write = (r_state == c_IDLE) ? mem_write : r_op_write;
    assign w_eff_idx   = (r_state == c_IDLE) ? address[c_IDX_W+1:2] : r_idx;
    assign w_eff_wdata = (r_state == c_IDLE) ? wdata : r_wdata;

    assign w_enter_resp = !reset && (r_state != c_RESP) && (w_next_state == c_RESP);

`ifdef MCU32X_MEM_ERR_EN
    logic w_in_bad;
    logic r_bad;

    assign w_in_bad  = (address[1:0] != 2'b00) || (address[31:c_IDX_W+2] != '0);
    assign w_eff_bad = (r_state == c_IDLE) ? w_in_bad : r_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bad <= 1'b0;
        end else if (w_accept) begin
            r_bad <= w_in_bad;
        end
    end

    assign err = ack && r_bad;
`else
    // Address bits outside the word index are deliberately ignored.
    logic [31-c_IDX_W:0] w_unused_addr;
    assign w_unused_addr = {address[31:c_IDX_W+2], address[1:0]};
    assign w_eff_bad     = 1'b0;
    assign err           = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE: begin
                w_next_state = c_IDLE;
                if (w_accept) begin
                    w_next_state = (WAIT_CYCLES == 0) ? c_RESP : c_WAIT;
                end
            end
            c_WAIT: begin
                w_next_state = (r_wait_cnt == c_WAIT_LAST) ? c_RESP : c_WAIT;
            end
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State, request latch and read-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= 4'd0;
            r_op_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'h0000_0000;
            r_rdata    <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op_write <= mem_write;
                r_idx      <= address[c_IDX_W+1:2];
                r_wdata    <= wdata;
                r_wait_cnt <= 4'd0;
            end else if (r_state == c_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (w_enter_resp && !w_eff_write && !w_eff_bad) begin
                r_rdata <= r_mem[w_eff_idx];
            end
        end
    end

    // Storage array: no reset, write commits on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_eff_write && !w_eff_bad) begin
            r_mem[w_eff_idx] <= w_eff_wdata;
        end
    end

    // Reset gates the handshake outputs so an aborted access shows nothing.
    assign ready = (r_state == c_IDLE) && !reset;
    assign ack   = (r_state == c_RESP) && !reset;
    assign rdata = r_rdata;

endmodule
`default_nettype wire
